// File: rtl/vstore_pkg.sv
// Shared widths, FSM state type and the lane-to-pixel conversion for the vector store writer.
// VSTORE_SATURATE_EN selects round-and-saturate conversion instead of plain truncation.
package vstore_pkg;

  localparam int LANES         = 6;
  localparam int LANE_WIDTH    = 19;
  localparam int FRAC_BITS     = 10;
  localparam int PIXEL_WIDTH   = 8;
  localparam int ADDRESS_WIDTH = 18;
  localparam int DATA_WIDTH    = LANES * LANE_WIDTH;
  localparam int WORD_WIDTH    = LANES * PIXEL_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } vstore_state_t;

  typedef logic [LANE_WIDTH-1:0]  lane_t;
  typedef logic [PIXEL_WIDTH-1:0] pixel_t;

`ifdef VSTORE_SATURATE_EN
  // Magnitude plus one half LSB; bit 18 set means the rounded integer reached 256.
  function automatic lane_t round_lane(input lane_t l);
    return {1'b0, l[LANE_WIDTH-2:0]} + lane_t'(1 << (FRAC_BITS - 1));
  endfunction

  function automatic logic lane_clamps(input lane_t l);
    lane_t r;
    r = round_lane(l);
    return l[LANE_WIDTH-1] | r[LANE_WIDTH-1];
  endfunction

  function automatic pixel_t lane_to_pixel(input lane_t l);
    lane_t r;
    r = round_lane(l);
    if (l[LANE_WIDTH-1])      return '0;
    else if (r[LANE_WIDTH-1]) return '1;
    else                      return r[PIXEL_WIDTH+FRAC_BITS-1:FRAC_BITS];
  endfunction
`else
  function automatic pixel_t lane_to_pixel(input lane_t l);
    return l[PIXEL_WIDTH+FRAC_BITS-1:FRAC_BITS];
  endfunction
`endif

endpackage

// File: rtl/vector_store_writer_if.sv
// Command, vector-input and memory-write signals of the vector store writer; slave is the engine side.
// The clipped flag exists only when VSTORE_SATURATE_EN is defined.
interface vector_store_writer_if;
  import vstore_pkg::*;

  logic                     start;
  logic [ADDRESS_WIDTH-1:0] baseAddress;
  logic [ADDRESS_WIDTH-1:0] vectorCount;
  logic                     inValid;
  logic                     inReady;
  logic [DATA_WIDTH-1:0]    inData;
  logic                     writeEnable;
  logic [ADDRESS_WIDTH-1:0] writeAddress;
  logic [WORD_WIDTH-1:0]    writeData;
  logic                     busy;
  logic                     done;
`ifdef VSTORE_SATURATE_EN
  logic                     clipped;

  modport master (output start, baseAddress, vectorCount, inValid, inData,
                  input  inReady, writeEnable, writeAddress, writeData, busy, done, clipped);
  modport slave  (input  start, baseAddress, vectorCount, inValid, inData,
                  output inReady, writeEnable, writeAddress, writeData, busy, done, clipped);
`else
  modport master (output start, baseAddress, vectorCount, inValid, inData,
                  input  inReady, writeEnable, writeAddress, writeData, busy, done);
  modport slave  (input  start, baseAddress, vectorCount, inValid, inData,
                  output inReady, writeEnable, writeAddress, writeData, busy, done);
`endif

endinterface

// File: rtl/pixel_packer.sv
// Combinational: converts every lane to a pixel and packs them, lane k into bits [8k+7:8k]; no backpressure.
// With VSTORE_SATURATE_EN it also reports whether any lane clamped.
module pixel_packer
  import vstore_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] lanes,
  output logic [WORD_WIDTH-1:0] word
`ifdef VSTORE_SATURATE_EN
  ,
  output logic                  clamp
`endif
);

  always_comb begin
    word = '0;
`ifdef VSTORE_SATURATE_EN
    clamp = 1'b0;
`endif
    for (int k = 0; k < LANES; k++) begin
      word[k*PIXEL_WIDTH +: PIXEL_WIDTH] = lane_to_pixel(lanes[k*LANE_WIDTH +: LANE_WIDTH]);
`ifdef VSTORE_SATURATE_EN
      clamp = clamp | lane_clamps(lanes[k*LANE_WIDTH +: LANE_WIDTH]);
`endif
    end
  end

endmodule

// File: rtl/vector_store_writer.sv
// Burst writer: each accepted vector becomes one pixel word written one cycle later at the next address.
// inReady comes from state/count only; clipped (VSTORE_SATURATE_EN) is sticky until the next accepted start.
module vector_store_writer
  import vstore_pkg::*;
(
  input logic                  clk,
  input logic                  reset,
  vector_store_writer_if.slave bus
);

  vstore_state_t            state, state_nxt;
  logic [ADDRESS_WIDTH-1:0] addr_cnt;
  logic [ADDRESS_WIDTH-1:0] remaining;
  logic [ADDRESS_WIDTH-1:0] wr_addr_q;
  logic [WORD_WIDTH-1:0]    wr_data_q;
  logic [WORD_WIDTH-1:0]    packed_word;
  logic                     wr_en_q;
  logic                     done_q;
  logic                     start_ok;
  logic                     in_rdy;
  logic                     xfer;
  logic                     last_xfer;
`ifdef VSTORE_SATURATE_EN
  logic                     clamp;
  logic                     clipped_q;
`endif

  pixel_packer u_packer (
    .lanes (bus.inData),
    .word  (packed_word)
`ifdef VSTORE_SATURATE_EN
    ,
    .clamp (clamp)
`endif
  );

  assign start_ok  = (state == IDLE) && bus.start;
  assign in_rdy    = (state == RUN) && (remaining != '0);
  assign xfer      = bus.inValid && in_rdy;
  assign last_xfer = xfer && (remaining == ADDRESS_WIDTH'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok && (bus.vectorCount != '0)) state_nxt = RUN;
      RUN:     if (last_xfer) state_nxt = DRAIN;
      DRAIN:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A zero-length start completes immediately: done next cycle, no write, never busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_cnt  <= '0;
      remaining <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      wr_en_q <= xfer;
      done_q  <= last_xfer || (start_ok && (bus.vectorCount == '0));
      if (start_ok) begin
        addr_cnt  <= bus.baseAddress;
        remaining <= bus.vectorCount;
      end else if (xfer) begin
        addr_cnt  <= addr_cnt + ADDRESS_WIDTH'(1);
        remaining <= remaining - ADDRESS_WIDTH'(1);
        wr_addr_q <= addr_cnt;
        wr_data_q <= packed_word;
      end
    end
  end

`ifdef VSTORE_SATURATE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              clipped_q <= 1'b0;
    else if (start_ok)      clipped_q <= 1'b0;
    else if (xfer && clamp) clipped_q <= 1'b1;
  end

  assign bus.clipped = clipped_q;
`endif

  assign bus.inReady      = in_rdy;
  assign bus.writeEnable  = wr_en_q;
  assign bus.writeAddress = wr_addr_q;
  assign bus.writeData    = wr_data_q;
  assign bus.busy         = (state != IDLE);
  assign bus.done         = done_q;

endmodule

// File: tb/tb_vector_store_writer.sv
// Self-checking bench for vector_store_writer: directed and randomized bursts against an arithmetic reference model.
module tb_vector_store_writer;
  import vstore_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   start_cyc;
  bit   busy_seen;

  logic [113:0] vec_q[$];
  int           xfer_cyc[$];
  logic [17:0]  w_addr[$];
  logic [47:0]  w_data[$];
  int           w_cyc[$];
  int           d_cyc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vector_store_writer_if bus ();
  vector_store_writer dut (.clk(clk), .reset(reset), .bus(bus));

  always @(negedge clk) begin
    if (bus.writeEnable === 1'b1) begin
      w_addr.push_back(bus.writeAddress);
      w_data.push_back(bus.writeData);
      w_cyc.push_back(cyc);
    end
    if (bus.done === 1'b1) d_cyc.push_back(cyc);
    if (bus.busy === 1'b1) busy_seen = 1'b1;
  end

  // Reference conversion straight from the fixed-point rules, on the lane taken as an unsigned 19-bit integer.
  function automatic logic [7:0] ref_pixel(input int lane);
`ifdef VSTORE_SATURATE_EN
    int v;
    if (lane >= 262144) return 8'd0;
    v = (lane + 512) / 1024;
    if (v > 255) return 8'd255;
    return v[7:0];
`else
    return 8'((lane / 1024) % 256);
`endif
  endfunction

  function automatic bit ref_clamp(input logic [113:0] vec);
    bit c = 0;
    for (int k = 0; k < 6; k++) begin
      int lane = int'(vec[k*19 +: 19]);
      if (lane >= 262144 || (lane + 512) / 1024 > 255) c = 1;
    end
    return c;
  endfunction

  function automatic logic [47:0] ref_word(input logic [113:0] vec);
    logic [47:0] w = '0;
    for (int k = 0; k < 6; k++) w = w | (48'(ref_pixel(int'(vec[k*19 +: 19]))) << (8 * k));
    return w;
  endfunction

  function automatic logic [17:0] ref_addr(input logic [17:0] base, input int i);
    return 18'((int'(base) + i) % 262144);
  endfunction

  function automatic logic [113:0] rand_vec();
    logic [113:0] v;
    for (int k = 0; k < 6; k++) v[k*19 +: 19] = 19'($urandom());
    return v;
  endfunction

  function automatic logic [113:0] fill_vec(input logic [18:0] lane);
    logic [113:0] v;
    for (int k = 0; k < 6; k++) v[k*19 +: 19] = lane;
    return v;
  endfunction

  // Issues start, then offers vec_q with random bubbles (bubble_pct) and/or a fixed gap after each transfer.
  task automatic run_burst(input logic [17:0] base, input int count, input int bubble_pct,
                           input int gap, input bit poke);
    int idx = 0;
    int guard = 0;
    int hold = 0;
    logic [127:0] junk;
    w_addr.delete(); w_data.delete(); w_cyc.delete(); d_cyc.delete(); xfer_cyc.delete();
    busy_seen = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.baseAddress = base; bus.vectorCount = 18'(count);
    start_cyc = cyc + 1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    while (idx < count && guard < 500) begin
      if (poke && guard == 0) begin
        bus.start = 1'b1; bus.baseAddress = base + 18'h100; bus.vectorCount = 18'd7;
      end else begin
        bus.start = 1'b0;
      end
      if (hold > 0) begin
        bus.inValid = 1'b0; hold--;
      end else begin
        bus.inValid = ($urandom_range(99) >= bubble_pct);
      end
      junk = {$urandom(), $urandom(), $urandom(), $urandom()};
      bus.inData = bus.inValid ? vec_q[idx] : junk[113:0];
      @(negedge clk);
      if (bus.inValid && bus.inReady) begin
        xfer_cyc.push_back(cyc + 1);
        idx++;
        hold = gap;
      end
      @(posedge clk); #1;
      guard++;
    end
    bus.inValid = 1'b0; bus.start = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.start = 1'b0; bus.inValid = 1'b0; bus.inData = '0;
    bus.baseAddress = '0; bus.vectorCount = '0;
    repeat (3) @(negedge clk);
    n_tests++; if (bus.inReady !== 1'b0) begin n_fail++; $display("FAIL reset_inReady got %b want 0", bus.inReady); end
    n_tests++; if (bus.writeEnable !== 1'b0) begin n_fail++; $display("FAIL reset_writeEnable got %b want 0", bus.writeEnable); end
    n_tests++; if (bus.writeAddress !== 18'h0) begin n_fail++; $display("FAIL reset_writeAddress got %h want 0", bus.writeAddress); end
    n_tests++; if (bus.writeData !== 48'h0) begin n_fail++; $display("FAIL reset_writeData got %h want 0", bus.writeData); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus.done); end
`ifdef VSTORE_SATURATE_EN
    n_tests++; if (bus.clipped !== 1'b0) begin n_fail++; $display("FAIL reset_clipped got %b want 0", bus.clipped); end
`endif
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_basic_burst;
    vec_q.delete();
    repeat (3) vec_q.push_back(fill_vec(19'h02800));
    run_burst(18'h00100, 3, 0, 0, 1'b0);
    n_tests++; if (w_addr.size() != 3) begin n_fail++; $display("FAIL basic_count got %0d want 3", w_addr.size()); end
    for (int i = 0; i < w_addr.size() && i < 3; i++) begin
      n_tests++; if (w_addr[i] !== 18'h00100 + 18'(i)) begin n_fail++; $display("FAIL basic_addr[%0d] got %h want %h", i, w_addr[i], 18'h00100 + 18'(i)); end
      n_tests++; if (w_data[i] !== 48'h0A0A0A0A0A0A) begin n_fail++; $display("FAIL basic_data[%0d] got %h want 0a0a0a0a0a0a", i, w_data[i]); end
      n_tests++; if (w_cyc[i] != start_cyc + 1 + i) begin n_fail++; $display("FAIL basic_timing[%0d] got cycle %0d want %0d", i, w_cyc[i], start_cyc + 1 + i); end
    end
    n_tests++; if (d_cyc.size() != 1 || d_cyc[0] != start_cyc + 3) begin n_fail++; $display("FAIL basic_done got %0d pulses (first at %0d) want 1 at %0d", d_cyc.size(), (d_cyc.size() > 0) ? d_cyc[0] : -1, start_cyc + 3); end
    n_tests++; if (bus.busy !== 1'b0 || bus.inReady !== 1'b0) begin n_fail++; $display("FAIL basic_idle_after got busy=%b inReady=%b want 0 0", bus.busy, bus.inReady); end
  endtask

  task automatic test_lane_order;
    logic [113:0] v;
    for (int k = 0; k < 6; k++) v[k*19 +: 19] = 19'((k + 1) << 10);
    vec_q.delete(); vec_q.push_back(v);
    run_burst(18'h00010, 1, 0, 0, 1'b0);
    n_tests++; if (w_data.size() != 1 || w_data[0] !== 48'h060504030201) begin n_fail++; $display("FAIL lane_order got %0d writes, data %h want 060504030201", w_data.size(), (w_data.size() > 0) ? w_data[0] : 48'h0); end
    n_tests++; if (d_cyc.size() != 1 || w_cyc.size() != 1 || d_cyc[0] != w_cyc[0]) begin n_fail++; $display("FAIL lane_order_done got %0d done pulses, %0d writes want 1 1 same cycle", d_cyc.size(), w_cyc.size()); end
  endtask

  task automatic test_bubbles_wrap;
    vec_q.delete(); vec_q.push_back(rand_vec()); vec_q.push_back(rand_vec());
    run_burst(18'h3FFFF, 2, 0, 2, 1'b0);
    n_tests++; if (w_addr.size() != 2) begin n_fail++; $display("FAIL wrap_count got %0d want 2", w_addr.size()); end
    if (w_addr.size() == 2) begin
      n_tests++; if (w_addr[0] !== 18'h3FFFF || w_addr[1] !== 18'h00000) begin n_fail++; $display("FAIL wrap_addr got %h %h want 3ffff 00000", w_addr[0], w_addr[1]); end
      n_tests++; if (w_data[0] !== ref_word(vec_q[0]) || w_data[1] !== ref_word(vec_q[1])) begin n_fail++; $display("FAIL wrap_data got %h %h want %h %h", w_data[0], w_data[1], ref_word(vec_q[0]), ref_word(vec_q[1])); end
      n_tests++; if (w_cyc[1] - w_cyc[0] != 3) begin n_fail++; $display("FAIL bubble_spacing got %0d want 3", w_cyc[1] - w_cyc[0]); end
    end
  endtask

  task automatic test_zero_and_ignored_start;
    vec_q.delete();
    run_burst(18'h00500, 0, 0, 0, 1'b0);
    n_tests++; if (d_cyc.size() != 1 || d_cyc[0] != start_cyc) begin n_fail++; $display("FAIL zero_done got %0d pulses (first at %0d) want 1 at %0d", d_cyc.size(), (d_cyc.size() > 0) ? d_cyc[0] : -1, start_cyc); end
    n_tests++; if (busy_seen !== 1'b0 || w_addr.size() != 0) begin n_fail++; $display("FAIL zero_quiet got busy_seen=%b writes=%0d want 0 0", busy_seen, w_addr.size()); end
    repeat (3) vec_q.push_back(rand_vec());
    run_burst(18'h00200, 3, 0, 0, 1'b1);
    n_tests++; if (w_addr.size() != 3 || d_cyc.size() != 1) begin n_fail++; $display("FAIL ignored_start_count got %0d writes %0d done want 3 1", w_addr.size(), d_cyc.size()); end
    for (int i = 0; i < w_addr.size() && i < 3; i++) begin
      n_tests++; if (w_addr[i] !== 18'h00200 + 18'(i) || w_data[i] !== ref_word(vec_q[i])) begin n_fail++; $display("FAIL ignored_start_write[%0d] got %h/%h want %h/%h", i, w_addr[i], w_data[i], 18'h00200 + 18'(i), ref_word(vec_q[i])); end
    end
  endtask

  task automatic test_conversion;
    logic [113:0] v = '0;
    v[18:0] = 19'h7FFFF; v[37:19] = 19'h3FE00; v[56:38] = 19'h00600;
    vec_q.delete(); vec_q.push_back(v);
    run_burst(18'h00020, 1, 0, 0, 1'b0);
`ifdef VSTORE_SATURATE_EN
    n_tests++; if (w_data.size() != 1 || w_data[0] !== 48'h00000002FF00) begin n_fail++; $display("FAIL convert_sat got %0d writes, data %h want 00000002ff00", w_data.size(), (w_data.size() > 0) ? w_data[0] : 48'h0); end
    n_tests++; if (bus.clipped !== 1'b1) begin n_fail++; $display("FAIL clipped_set got %b want 1", bus.clipped); end
    vec_q.delete(); vec_q.push_back(fill_vec(19'h00600));
    run_burst(18'h00021, 1, 0, 0, 1'b0);
    n_tests++; if (bus.clipped !== 1'b0) begin n_fail++; $display("FAIL clipped_clear got %b want 0", bus.clipped); end
`else
    n_tests++; if (w_data.size() != 1 || w_data[0] !== 48'h00000001FFFF) begin n_fail++; $display("FAIL convert_trunc got %0d writes, data %h want 00000001ffff", w_data.size(), (w_data.size() > 0) ? w_data[0] : 48'h0); end
`endif
  endtask

  task automatic test_random_bursts;
    for (int b = 0; b < 5; b++) begin
      logic [17:0] base = (b == 0) ? 18'h3FFFD : 18'($urandom());
      int count = $urandom_range(1, 6);
      vec_q.delete();
      for (int i = 0; i < count; i++) vec_q.push_back(rand_vec());
      run_burst(base, count, 30, 0, 1'b0);
      n_tests++; if (w_addr.size() != count || xfer_cyc.size() != count) begin n_fail++; $display("FAIL rand%0d_count got %0d writes %0d transfers want %0d", b, w_addr.size(), xfer_cyc.size(), count); end
      for (int i = 0; i < w_addr.size() && i < count && i < xfer_cyc.size(); i++) begin
        n_tests++;
        if (w_addr[i] !== ref_addr(base, i) || w_data[i] !== ref_word(vec_q[i]) || w_cyc[i] != xfer_cyc[i]) begin
          n_fail++;
          $display("FAIL rand%0d_write[%0d] got %h/%h@%0d want %h/%h@%0d", b, i, w_addr[i], w_data[i], w_cyc[i], ref_addr(base, i), ref_word(vec_q[i]), xfer_cyc[i]);
        end
      end
      n_tests++; if (d_cyc.size() != 1 || w_cyc.size() == 0 || d_cyc[0] != w_cyc[w_cyc.size()-1]) begin n_fail++; $display("FAIL rand%0d_done got %0d pulses want 1 on last write", b, d_cyc.size()); end
`ifdef VSTORE_SATURATE_EN
      begin
        bit any = 0;
        foreach (vec_q[i]) any |= ref_clamp(vec_q[i]);
        n_tests++; if (bus.clipped !== any) begin n_fail++; $display("FAIL rand%0d_clipped got %b want %b", b, bus.clipped, any); end
      end
`endif
    end
  endtask

  task automatic test_mid_reset;
    int guard = 0;
    vec_q.delete();
    repeat (4) vec_q.push_back(rand_vec());
    @(posedge clk); #1;
    bus.start = 1'b1; bus.baseAddress = 18'h01000; bus.vectorCount = 18'd4;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.inValid = 1'b1; bus.inData = vec_q[0];
    @(negedge clk);
    while (!bus.inReady && guard < 20) begin @(negedge clk); guard++; end
    @(posedge clk); #1;
    bus.inValid = 1'b0;
    n_tests++; if (bus.writeEnable !== 1'b1 || bus.writeAddress !== 18'h01000) begin n_fail++; $display("FAIL midreset_inflight got we=%b addr=%h want 1 01000", bus.writeEnable, bus.writeAddress); end
    reset = 1'b1; #1;
    n_tests++;
    if (bus.writeEnable !== 1'b0 || bus.writeAddress !== 18'h0 || bus.writeData !== 48'h0 ||
        bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.inReady !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_outputs got we=%b addr=%h data=%h busy=%b done=%b rdy=%b want all 0",
               bus.writeEnable, bus.writeAddress, bus.writeData, bus.busy, bus.done, bus.inReady);
    end
    @(negedge clk); reset = 1'b0;
    vec_q.delete(); vec_q.push_back(rand_vec()); vec_q.push_back(rand_vec());
    run_burst(18'h02000, 2, 0, 0, 1'b0);
    n_tests++; if (w_addr.size() != 2 || d_cyc.size() != 1) begin n_fail++; $display("FAIL midreset_restart_count got %0d writes %0d done want 2 1", w_addr.size(), d_cyc.size()); end
    for (int i = 0; i < w_addr.size() && i < 2; i++) begin
      n_tests++; if (w_addr[i] !== 18'h02000 + 18'(i) || w_data[i] !== ref_word(vec_q[i])) begin n_fail++; $display("FAIL midreset_restart[%0d] got %h/%h want %h/%h", i, w_addr[i], w_data[i], 18'h02000 + 18'(i), ref_word(vec_q[i])); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_burst();
    test_lane_order();
    test_bubbles_wrap();
    test_zero_and_ignored_start();
    test_conversion();
    test_random_bursts();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
